// File: rtl/conv_stream_pkg.sv
// conv_stream_pkg: shared widths, occupancy states and flat result indexing for the conv output path
package conv_stream_pkg;
  localparam int OPAQUE_WIDTH = 8;
  localparam int RES_WIDTH_MULT = 4;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_t;
  function automatic int flat_idx(input int d, input int h, input int w, input int rh, input int rw);
    return d * rh * rw + h * rw + w;
  endfunction
endpackage

// File: rtl/conv_result_streamer_if.sv
// conv_result_streamer_if: frame input and beat output handshake bundle
interface conv_result_streamer_if
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RESULT_W = 6,
  parameter int RESULT_H = 6,
  parameter int RESULT_D = 4,
  parameter int LANES = 1
);
  localparam int RES_WIDTH = DATA_WIDTH * RES_WIDTH_MULT;
  localparam int NUM_RES = RESULT_D * RESULT_H * RESULT_W;
  localparam int IDX_WIDTH = NUM_RES > 1 ? $clog2(NUM_RES) : 1;
  logic in_valid;
  logic in_ready;
  logic [NUM_RES*RES_WIDTH-1:0] result_data_in;
  logic [OPAQUE_WIDTH-1:0] opaque_in;
  logic out_valid;
  logic out_ready;
  logic [LANES*RES_WIDTH-1:0] out_data;
  logic [IDX_WIDTH-1:0] out_index;
  logic out_first;
  logic out_last;
  logic [OPAQUE_WIDTH-1:0] out_opaque;
  modport master (
    output in_valid, result_data_in, opaque_in, out_ready,
    input in_ready, out_valid, out_data, out_index, out_first, out_last, out_opaque
  );
  modport slave (
    input in_valid, result_data_in, opaque_in, out_ready,
    output in_ready, out_valid, out_data, out_index, out_first, out_last, out_opaque
  );
endinterface

// File: rtl/conv_frame_pingpong.sv
// conv_frame_pingpong: two-entry frame buffer with write/read-release strobes and occupancy FSM
module conv_frame_pingpong
  import conv_stream_pkg::*;
#(
  parameter int FRAME_W = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_valid,
  input  logic [FRAME_W-1:0] wr_data,
  output logic               wr_ready,
  input  logic               rd_done,
  output logic               rd_valid,
  output logic [FRAME_W-1:0] rd_data
);
  occ_t state, state_nxt;
  logic wr_ptr, rd_ptr, wr;
  logic [FRAME_W-1:0] mem [2];
  assign wr_ready = !reset && state != FULL;
  assign rd_valid = state != EMPTY;
  assign wr = wr_valid && wr_ready;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      wr_ptr <= wr_ptr ^ wr;
      rd_ptr <= rd_ptr ^ rd_done;
    end
  end
  always_ff @(posedge clk) if (wr) mem[wr_ptr] <= wr_data;
  always_comb begin
    state_nxt = state;
    state_nxt = (wr && !rd_done) ? (state == EMPTY ? ONE : FULL) :
                (!wr && rd_done) ? (state == FULL ? ONE : EMPTY) : state;
  end
endmodule

// File: rtl/conv_result_streamer.sv
// conv_result_streamer: buffers whole conv result frames and streams them LANES words per beat
module conv_result_streamer
  import conv_stream_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RESULT_W = 6,
  parameter int RESULT_H = 6,
  parameter int RESULT_D = 4,
  parameter int LANES = 1
) (
  input logic clk,
  input logic reset,
  conv_result_streamer_if.slave bus
);
  localparam int RES_WIDTH = DATA_WIDTH * RES_WIDTH_MULT;
  localparam int NUM_RES = RESULT_D * RESULT_H * RESULT_W;
  localparam int IDX_WIDTH = NUM_RES > 1 ? $clog2(NUM_RES) : 1;
  localparam int FRAME_W = NUM_RES * RES_WIDTH + OPAQUE_WIDTH;
  generate
    if (NUM_RES % LANES != 0) begin : g_lanes_chk
      $error("LANES must divide NUM_RES");
    end
  endgenerate
  logic [IDX_WIDTH-1:0] idx;
  logic [FRAME_W-1:0] frame;
  logic last, beat, rd_done;
  assign last = idx == IDX_WIDTH'(NUM_RES - LANES);
  assign beat = bus.out_valid && bus.out_ready;
  assign rd_done = beat && last;
  conv_frame_pingpong #(.FRAME_W(FRAME_W)) u_pp (
    .clk      (clk),
    .reset    (reset),
    .wr_valid (bus.in_valid),
    .wr_data  ({bus.opaque_in, bus.result_data_in}),
    .wr_ready (bus.in_ready),
    .rd_done  (rd_done),
    .rd_valid (bus.out_valid),
    .rd_data  (frame)
  );
  always_ff @(posedge clk) begin
    if (reset) idx <= '0;
    else if (beat) idx <= last ? '0 : idx + IDX_WIDTH'(LANES);
  end
  assign bus.out_data = frame[int'(idx)*RES_WIDTH +: LANES*RES_WIDTH];
  assign bus.out_opaque = frame[FRAME_W-1 -: OPAQUE_WIDTH];
  assign bus.out_index = idx;
  assign bus.out_first = idx == '0;
  assign bus.out_last = last;
endmodule

// File: tb/tb_conv_result_streamer.sv
// tb_conv_result_streamer: directed table and sequence checks on a 2x2x2 result frame, LANES 1 and 4
module tb_conv_result_streamer;
  import conv_stream_pkg::*;
  typedef struct {
    logic [31:0] data;
    logic [2:0]  idx;
    logic        first;
    logic        last;
  } vec_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int ncmp = 0;
  int nerr = 0;
  vec_t tbl [8];
  logic [255:0] fa, fb, fc;
  conv_result_streamer_if #(.DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(2), .RESULT_D(2), .LANES(1)) ia ();
  conv_result_streamer_if #(.DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(2), .RESULT_D(2), .LANES(4)) ib ();
  conv_result_streamer #(.DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(2), .RESULT_D(2), .LANES(1)) dut_a (
    .clk(clk), .reset(rst), .bus(ia.slave));
  conv_result_streamer #(.DATA_WIDTH(8), .RESULT_W(2), .RESULT_H(2), .RESULT_D(2), .LANES(4)) dut_b (
    .clk(clk), .reset(rst), .bus(ib.slave));
  always #5 clk = ~clk;
  function automatic logic [255:0] mk(input logic [31:0] base);
    logic [255:0] f;
    int n;
    f = '0;
    for (int d = 0; d < 2; d++)
      for (int h = 0; h < 2; h++)
        for (int w = 0; w < 2; w++) begin
          n = flat_idx(d, h, w, 2, 2);
          f[n*32 +: 32] = base + 32'(n);
        end
    return f;
  endfunction
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic put(input logic [255:0] f, input logic [7:0] t);
    ia.in_valid = 1'b1;
    ia.result_data_in = f;
    ia.opaque_in = t;
    tick;
    ia.in_valid = 1'b0;
  endtask
  task automatic stream(input string nm, input logic [31:0] base, input logic [7:0] t, input int from);
    for (int i = from; i < 8; i++) begin
      chk($sformatf("%s valid %0d", nm, i), 128'(ia.out_valid), 128'(1));
      chk($sformatf("%s data %0d", nm, i), 128'(ia.out_data), 128'(base + 32'(i)));
      chk($sformatf("%s index %0d", nm, i), 128'(ia.out_index), 128'(i));
      chk($sformatf("%s tag %0d", nm, i), 128'(ia.out_opaque), 128'(t));
      tick;
    end
  endtask
  initial begin
    fa = mk(32'hA000);
    fb = mk(32'hB000);
    fc = mk(32'hD000);
    for (int i = 0; i < 8; i++) tbl[i] = '{32'hA000 + 32'(i), 3'(i), i == 0, i == 7};
    ia.in_valid = 1'b0; ia.result_data_in = '0; ia.opaque_in = '0; ia.out_ready = 1'b0;
    ib.in_valid = 1'b0; ib.result_data_in = '0; ib.opaque_in = '0; ib.out_ready = 1'b0;
    tick;
    tick;
    chk("reset in_ready", 128'(ia.in_ready), 128'(0));
    chk("reset out_valid", 128'(ia.out_valid), 128'(0));
    chk("reset index", 128'(ia.out_index), 128'(0));
    chk("reset first", 128'(ia.out_first), 128'(1));
    chk("reset last", 128'(ia.out_last), 128'(0));
    rst = 1'b0;
    #1;
    chk("post reset in_ready", 128'(ia.in_ready), 128'(1));
    ia.out_ready = 1'b1;
    put(fa, 8'h5A);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t1 valid %0d", i), 128'(ia.out_valid), 128'(1));
      chk($sformatf("t1 data %0d", i), 128'(ia.out_data), 128'(tbl[i].data));
      chk($sformatf("t1 index %0d", i), 128'(ia.out_index), 128'(tbl[i].idx));
      chk($sformatf("t1 first %0d", i), 128'(ia.out_first), 128'(tbl[i].first));
      chk($sformatf("t1 last %0d", i), 128'(ia.out_last), 128'(tbl[i].last));
      chk($sformatf("t1 tag %0d", i), 128'(ia.out_opaque), 128'(8'h5A));
      tick;
    end
    chk("t1 idle", 128'(ia.out_valid), 128'(0));
    ia.out_ready = 1'b0;
    put(fa, 8'h5A);
    chk("t2 one in_ready", 128'(ia.in_ready), 128'(1));
    put(fb, 8'hC3);
    chk("t2 full in_ready", 128'(ia.in_ready), 128'(0));
    ia.in_valid = 1'b1; ia.result_data_in = fc; ia.opaque_in = 8'h77;
    tick;
    tick;
    chk("t2 still full", 128'(ia.in_ready), 128'(0));
    ia.in_valid = 1'b0;
    ia.out_ready = 1'b1;
    stream("t2 A", 32'hA000, 8'h5A, 0);
    stream("t2 B", 32'hB000, 8'hC3, 0);
    chk("t2 idle", 128'(ia.out_valid), 128'(0));
    ia.out_ready = 1'b0;
    put(fa, 8'h5A);
    ia.out_ready = 1'b1;
    repeat (3) tick;
    ia.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("t3 stall data %0d", i), 128'(ia.out_data), 128'(32'hA003));
      chk($sformatf("t3 stall valid %0d", i), 128'(ia.out_valid), 128'(1));
      chk($sformatf("t3 stall index %0d", i), 128'(ia.out_index), 128'(3));
      tick;
    end
    ia.out_ready = 1'b1;
    stream("t3 resume", 32'hA000, 8'h5A, 3);
    chk("t3 idle", 128'(ia.out_valid), 128'(0));
    put(fa, 8'h5A);
    repeat (7) tick;
    chk("t4 at last", 128'(ia.out_last), 128'(1));
    ia.in_valid = 1'b1; ia.result_data_in = fb; ia.opaque_in = 8'hC3;
    chk("t4 in_ready", 128'(ia.in_ready), 128'(1));
    tick;
    ia.in_valid = 1'b0;
    chk("t4 B0 first", 128'(ia.out_first), 128'(1));
    stream("t4 B", 32'hB000, 8'hC3, 0);
    chk("t4 idle", 128'(ia.out_valid), 128'(0));
    ia.out_ready = 1'b0;
    put(fa, 8'h5A);
    put(fb, 8'hC3);
    ia.out_ready = 1'b1;
    repeat (5) tick;
    ia.out_ready = 1'b0;
    chk("t6 index", 128'(ia.out_index), 128'(5));
    chk("t6 full", 128'(ia.in_ready), 128'(0));
    rst = 1'b1;
    tick;
    chk("t6 rst out_valid", 128'(ia.out_valid), 128'(0));
    chk("t6 rst in_ready", 128'(ia.in_ready), 128'(0));
    rst = 1'b0;
    #1;
    chk("t6 in_ready", 128'(ia.in_ready), 128'(1));
    ia.out_ready = 1'b1;
    put(fc, 8'h77);
    chk("t6 first", 128'(ia.out_first), 128'(1));
    stream("t6 C", 32'hD000, 8'h77, 0);
    chk("t6 idle", 128'(ia.out_valid), 128'(0));
    ib.out_ready = 1'b1;
    ib.in_valid = 1'b1; ib.result_data_in = fa; ib.opaque_in = 8'h5A;
    tick;
    ib.in_valid = 1'b0;
    chk("t5 b0 valid", 128'(ib.out_valid), 128'(1));
    chk("t5 b0 data", ib.out_data, 128'h0000A003_0000A002_0000A001_0000A000);
    chk("t5 b0 index", 128'(ib.out_index), 128'(0));
    chk("t5 b0 first", 128'(ib.out_first), 128'(1));
    chk("t5 b0 last", 128'(ib.out_last), 128'(0));
    tick;
    chk("t5 b1 data", ib.out_data, 128'h0000A007_0000A006_0000A005_0000A004);
    chk("t5 b1 index", 128'(ib.out_index), 128'(4));
    chk("t5 b1 first", 128'(ib.out_first), 128'(0));
    chk("t5 b1 last", 128'(ib.out_last), 128'(1));
    chk("t5 b1 tag", 128'(ib.out_opaque), 128'(8'h5A));
    tick;
    chk("t5 idle", 128'(ib.out_valid), 128'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
